// File: rtl/sw_debounce_pkg.sv
// Shared defaults and helpers for the sw_debounce8 switch-conditioning block.
// The optional tick prescaler is enabled with DEBOUNCE_TICK_EN.
package sw_debounce_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_STABLE_CYCLES = 50000;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_TICK_DIV      = 1000;

    // Per-channel result handed from each debounce_bit to the top level.
    typedef struct packed {
        logic stable;
        logic upd;
    } db_rsp_t;

    // True when a CNT_W-bit counter can hold STABLE_CYCLES-1.
    function automatic bit cnt_w_ok(input int cnt_w, input int stable_cycles);
        if (cnt_w < 1 || stable_cycles < 1) return 1'b0;
        if (cnt_w >= 32) return 1'b1;
        return (longint'(1) << cnt_w) > longint'(stable_cycles - 1);
    endfunction

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: 2-flop synchroniser, stability counter and stable flop.
// upd is combinational and marks the edge on which stable takes a new value.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    tick,
    input  logic    sw_in,
    output db_rsp_t rsp
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd;

    // Agreement clears every cycle; only qualified cycles advance or commit.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        upd      = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_MAX) begin
                upd      = 1'b1;
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rsp.stable = stable_q;
    assign rsp.upd    = upd;

endmodule

// File: rtl/sw_debounce8.sv
// Debounced, synchronised switch vector feeding the 8-to-3 priority encoder.
// Define DEBOUNCE_TICK_EN to count stability in prescaler ticks instead of clocks.
module sw_debounce8
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
`ifdef DEBOUNCE_TICK_EN
    ,
    parameter int TICK_DIV      = DEF_TICK_DIV
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_stable,
    output logic             changed,
    output logic             any_active
);

    localparam bit CFG_OK = cnt_w_ok(CNT_W, STABLE_CYCLES);

    if (!CFG_OK) begin : g_cfg_err
        $error("sw_debounce8: CNT_W too small for STABLE_CYCLES");
    end

    logic                  tick;
    db_rsp_t [WIDTH-1:0]   rsp;
    logic    [WIDTH-1:0]   stable_v;
    logic    [WIDTH-1:0]   upd_v;
    logic                  changed_q, changed_d;
    logic                  any_active_q, any_active_d;

`ifdef DEBOUNCE_TICK_EN
    localparam int TICK_W = div_width(TICK_DIV);

    logic [TICK_W-1:0] pre_q, pre_d;

    always_comb begin
        tick  = (pre_q == TICK_W'(TICK_DIV - 1));
        pre_d = tick ? '0 : pre_q + TICK_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .sw_in(sw_in[g]),
            .rsp  (rsp[g])
        );
        assign stable_v[g] = rsp[g].stable;
        assign upd_v[g]    = rsp[g].upd;
    end

    // upd marks a toggle, so stable^upd is next cycle's sw_stable.
    always_comb begin
        changed_d    = |upd_v;
        any_active_d = |(stable_v ^ upd_v);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q    <= 1'b0;
            any_active_q <= 1'b0;
        end else begin
            changed_q    <= changed_d;
            any_active_q <= any_active_d;
        end
    end

    assign sw_stable  = stable_v;
    assign changed    = changed_q;
    assign any_active = any_active_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Self-checking bench for sw_debounce8: hand tables for the corner cases plus
// randomized stimulus against a history-window reference model.
module tb_sw_debounce8;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;
`ifdef DEBOUNCE_TICK_EN
    localparam int D  = 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_stable;
    logic         changed;
    logic         any_active;

    always #5 clk = ~clk;

    sw_debounce8 #(
        .WIDTH(W), .STABLE_CYCLES(N), .CNT_W(CW)
`ifdef DEBOUNCE_TICK_EN
        , .TICK_DIV(D)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .sw_stable (sw_stable),
        .changed   (changed),
        .any_active(any_active)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a bit flips when the most recent N qualified sync2
    // samples all disagree with it, with no agreeing sample in between.
    logic [W-1:0] m_s1, m_s2, m_stab;
    logic         m_chg, m_any;
    int           m_edge;
    logic [W-1:0] h_s2[$];
    bit           h_tick[$];

    function automatic void m_reset();
        m_s1 = '0; m_s2 = '0; m_stab = '0; m_chg = 1'b0; m_any = 1'b0;
        m_edge = 0;
        h_s2.delete(); h_tick.delete();
    endfunction

    function automatic void m_step(input logic [W-1:0] v);
        bit           tk;
        logic [W-1:0] nxt;
`ifdef DEBOUNCE_TICK_EN
        tk = ((m_edge % D) == D - 1);
`else
        tk = 1'b1;
`endif
        m_edge++;
        h_s2.push_back(m_s2);
        h_tick.push_back(tk);
        if (h_s2.size() > 64) begin
            void'(h_s2.pop_front());
            void'(h_tick.pop_front());
        end
        nxt = m_stab;
        if (tk) begin
            for (int b = 0; b < W; b++) begin
                int cnt = 0;
                for (int k = h_s2.size() - 1; k >= 0; k--) begin
                    if (h_s2[k][b] == m_stab[b]) break;
                    if (h_tick[k]) cnt++;
                    if (cnt >= N) break;
                end
                if (cnt >= N) nxt[b] = ~m_stab[b];
            end
        end
        m_chg  = (nxt != m_stab);
        m_stab = nxt;
        m_any  = |nxt;
        m_s2   = m_s1;
        m_s1   = v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] es,
                         input logic ec, input logic ea);
        checks++;
        if (sw_stable !== es || changed !== ec || any_active !== ea) begin
            errors++;
            $display("FAIL %s: got stable=%h changed=%b any=%b, want stable=%h changed=%b any=%b",
                     name, sw_stable, changed, any_active, es, ec, ea);
        end
    endtask

    // Drive one input value, advance one edge, compare with the model.
    task automatic step(input logic [W-1:0] v, input string name);
        sw_in = v;
        @(posedge clk);
        if (rst_n) m_step(v);
        else       m_reset();
        #1;
        check(name, m_stab, m_chg, m_any);
    endtask

    typedef struct {
        logic [W-1:0] sw;
        logic [W-1:0] st;
        logic         chg;
        logic         any;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [W-1:0] sw, input logic [W-1:0] st,
                                input logic chg, input logic any);
        vec_t v;
        v.sw = sw; v.st = st; v.chg = chg; v.any = any;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [W-1:0] rv;

        m_reset();
        for (int i = 0; i < 10; i++) step(8'hFF, "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

`ifndef DEBOUNCE_TICK_EN
        for (int k = 1; k <= 6; k++) begin
            step(8'hFF, "release_model");
            check("release_hand", (k == 6) ? 8'hFF : 8'h00, k == 6, k == 6);
        end
        for (int i = 0; i < 10; i++) step(8'h00, "settle_00");
        check("settle_00_hand", 8'h00, 1'b0, 1'b0);

        // Clean step on bit7, then a bounce on bit3.
        for (int k = 0; k < 5; k++) add(8'h80, 8'h00, 1'b0, 1'b0);
        add(8'h80, 8'h80, 1'b1, 1'b1);
        add(8'h80, 8'h80, 1'b0, 1'b1);
        add(8'h88, 8'h80, 1'b0, 1'b1);
        add(8'h80, 8'h80, 1'b0, 1'b1);
        add(8'h88, 8'h80, 1'b0, 1'b1);
        add(8'h80, 8'h80, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) add(8'h88, 8'h80, 1'b0, 1'b1);
        add(8'h88, 8'h88, 1'b1, 1'b1);
        add(8'h88, 8'h88, 1'b0, 1'b1);
        foreach (tbl[i]) begin
            step(tbl[i].sw, "table_model");
            check($sformatf("table[%0d]", i), tbl[i].st, tbl[i].chg, tbl[i].any);
        end

        // Three-cycle glitch on bit0 never reaches the output.
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            step((k < 3) ? 8'h89 : 8'h88, "glitch_model");
            if (changed) pulses++;
        end
        checks++;
        if (pulses != 0 || sw_stable !== 8'h88) begin
            errors++;
            $display("FAIL glitch: got pulses=%0d stable=%h, want pulses=0 stable=88", pulses, sw_stable);
        end

        // Bits 7 and 1 change together: one edge, one pulse.
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step(8'h0A, "simul_model");
            if (changed) pulses++;
            if (k == 5) check("simul_edge", 8'h0A, 1'b1, 1'b1);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL simul_pulses: got %0d, want 1", pulses);
        end

        // Async reset two cycles into a count on bit5.
        for (int k = 0; k < 4; k++) step(8'h2A, "midcount_model");
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_clear", 8'h00, 1'b0, 1'b0);
        step(8'h2A, "in_reset");
        step(8'h2A, "in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(8'h2A, "restart_model");
            check("restart_hand", (k == 6) ? 8'h2A : 8'h00, k == 6, k == 6);
        end
`else
        // Step on bit2: commit must land on a tick edge after 4 ticks.
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            step(8'h04, "tick_model");
            if (changed) begin
                pulses++;
                checks++;
                if (((m_edge - 1) % D) != D - 1) begin
                    errors++;
                    $display("FAIL tick_align: got change at edge %0d, want tick edge", m_edge);
                end
            end
        end
        checks++;
        if (pulses != 1 || sw_stable !== 8'h04) begin
            errors++;
            $display("FAIL tick_step: got pulses=%0d stable=%h, want pulses=1 stable=04", pulses, sw_stable);
        end
`endif

        // Randomized holds and short glitches against the model.
        for (int i = 0; i < 400; i++) begin
            rv = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                step(rv, "rand_glitch");
            end else begin
                int hold = $urandom_range(1, 10);
                for (int k = 0; k < hold; k++) step(rv, "rand_hold");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
